fract_write_arbiter: RTL and testbench
======================================

FRACT_WRITE_ARBITER -- requirements
Module: fract_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of solver requesters (2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 19, meaning the frame-buffer address width.
REQ-003 The block SHALL have parameter DATA_W, default 3, meaning the pixel colour width.
REQ-004 The block SHALL have parameter FRAME_PIXELS, default 307200, meaning the pixels per frame (640x480).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port clear_start, input, 1 bit: one-cycle request to clear the frame.
REQ-008 The block SHALL have port clear_color, input, DATA_W bits: the fill colour, sampled when clear_start is accepted.
REQ-009 The block SHALL have port clear_busy, output, 1 bit: high while in CLEAR.
REQ-010 The block SHALL have port clear_done, output, 1 bit: one-cycle pulse after the last clear write.
REQ-011 The block SHALL have port req_valid, input, NUM_REQ bits: per-solver write request.
REQ-012 The block SHALL have port req_addr, input, NUM_REQ*ADDR_W bits: packed addresses, solver i at [i*ADDR_W +: ADDR_W].
REQ-013 The block SHALL have port req_data, input, NUM_REQ*DATA_W bits: packed colours, same packing as req_addr.
REQ-014 The block SHALL have port req_ready, output, NUM_REQ bits: one-hot (or zero) grant.
REQ-015 The block SHALL have port wraddress, output, ADDR_W bits: the frame-buffer write address.
REQ-016 The block SHALL have port data, output, DATA_W bits: the frame-buffer write data.
REQ-017 The block SHALL have port wren, output, 1 bit: the frame-buffer write enable.
REQ-018 The block SHALL have port pixel_count, output, ADDR_W bits: solver writes accepted since the last clear.
REQ-019 The block SHALL have port frame_done, output, 1 bit: level, high once pixel_count equals FRAME_PIXELS.

Function
REQ-020 The block SHALL implement two states, ARB and CLEAR.
REQ-021 In ARB with clear_start=1, the block SHALL go to CLEAR next cycle, latch clear_color, and set the clear address to 0.
REQ-022 clear_start SHALL take priority over solver requests in the same cycle; req_ready SHALL be 0 in that cycle.
REQ-023 In CLEAR, the block SHALL drive wren=1, wraddress = clear address, data = latched colour every cycle, with the address incrementing by 1.
REQ-024 After writing address FRAME_PIXELS-1, the block SHALL return to ARB, pulse clear_done for one cycle, and reset pixel_count to 0.
REQ-025 In CLEAR, req_ready SHALL be all zero, and clear_start SHALL be ignored (no restart).
REQ-026 In ARB, req_ready SHALL be combinational: one-hot on the first asserted req_valid searching from the round-robin pointer upward with wrap-around; zero if none are valid.
REQ-027 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high.
REQ-028 On a transfer, the pointer SHALL become (i+1) mod NUM_REQ; otherwise the pointer SHALL hold.
REQ-029 A transfer SHALL produce wren=1 with the solver's address and data on the next cycle (1-cycle registered latency); otherwise wren=0.
REQ-030 pixel_count SHALL increment per transfer and saturate at FRAME_PIXELS.
REQ-031 wraddress and data SHALL hold their last values while wren=0.
REQ-032 Sustained throughput SHALL be one write per cycle, with no bubble between consecutive grants.

Reset
REQ-033 On reset_n=0, asynchronously: state=ARB, pointer=0, wren=0, wraddress=0, data=0, clear_busy=0, clear_done=0, pixel_count=0, frame_done=0.
REQ-034 While in reset, req_ready SHALL be 0.
REQ-035 Reset asserted mid-CLEAR SHALL abort the clear with no further writes.

Configuration
REQ-036 With macro FRACT_ARB_BOUNDS_CHECK_EN defined, a transfer with address >= FRAME_PIXELS SHALL be accepted (ready given, pointer advances) but produce wren=0 and no pixel_count increment.
REQ-037 With FRACT_ARB_BOUNDS_CHECK_EN undefined, all addresses SHALL be forwarded unchecked.

Verification
REQ-038 Reset, then clear_start with clear_color=3'b101: the bench SHALL see 307200 consecutive writes, addr 0..307199, data 5, then clear_done for one cycle and clear_busy low.
REQ-039 All 4 solvers valid continuously from pointer 0: grants SHALL follow 0,1,2,3,0,..., with wren high every cycle starting one cycle after the first grant.
REQ-040 Only solver 2 valid, addr 100, data 6: the bench SHALL see req_ready=4'b0100, then next cycle wren=1, wraddress=100, data=6, pixel_count=1.
REQ-041 clear_start and req_valid=4'b1111 in the same cycle: req_ready SHALL be 0 and CLEAR SHALL start; solver writes SHALL resume only after clear_done.
REQ-042 reset_n pulsed low at clear address 1000: wren SHALL be 0 immediately and state SHALL be ARB after release.
REQ-043 With FRACT_ARB_BOUNDS_CHECK_EN, solver 0 addr 307200: ready SHALL be 1, wren SHALL stay 0, and pixel_count SHALL be unchanged.

Source files
------------

// File: rtl/fract_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fract_write_arbiter
// Function : Round-robin arbiter merging solver pixel writes into one frame
//            buffer port, with a full-frame clear engine.
// Option   : FRACT_ARB_BOUNDS_CHECK_EN drops writes addressed past the frame.
// Revision : 1.0 - initial release
// ============================================================================
module fract_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 3,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear_start,
  input  logic [DATA_W-1:0]         clear_color,
  output logic                      clear_busy,
  output logic                      clear_done,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         wraddress,
  output logic [DATA_W-1:0]         data,
  output logic                      wren,
  output logic [ADDR_W-1:0]         pixel_count,
  output logic                      frame_done
);

  localparam int                PTR_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] c_FRAME_PIXELS = ADDR_W'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR    = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [PTR_W-1:0]  c_LAST_REQ     = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]    c_NUM_REQ      = (PTR_W + 1)'(NUM_REQ);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PTR_W-1:0]    r_ptr;
  logic                r_wren;
  logic [ADDR_W-1:0]   r_wraddress;
  logic [DATA_W-1:0]   r_data;
  logic                r_clear_done;
  logic [ADDR_W-1:0]   r_pixel_count;

  logic [NUM_REQ-1:0]  w_grant;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic                w_found;
  logic [PTR_W:0]      w_sum;
  logic [PTR_W-1:0]    w_idx;
  logic                w_arb_open;
  logic                w_xfer;
  logic                w_in_range;
  logic                w_write;
  logic                w_clear_last;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic [DATA_W-1:0]   w_gnt_data;

  // First valid requester at or above the pointer, wrapping round.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(k);
      if (w_sum >= c_NUM_REQ) begin
        w_sum = w_sum - c_NUM_REQ;
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && req_valid[w_idx]) begin
        w_found        = 1'b1;
        w_gnt_idx      = w_idx;
        w_grant[w_idx] = 1'b1;
      end
    end
  end

  assign w_arb_open   = reset_n && (r_state == ST_ARB) && !clear_start;
  assign req_ready    = w_arb_open ? w_grant : '0;
  assign w_xfer       = w_arb_open && w_found;
  assign w_gnt_addr   = req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
  assign w_gnt_data   = req_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_clear_last = (r_state == ST_CLEAR) && (r_wraddress == c_LAST_ADDR);

`ifdef FRACT_ARB_BOUNDS_CHECK_EN
  assign w_in_range = (w_gnt_addr < c_FRAME_PIXELS);
`else
  assign w_in_range = 1'b1;
`endif

  assign w_write = w_xfer && w_in_range;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ARB:   if (clear_start) w_state_next = ST_CLEAR;
      ST_CLEAR: if (w_clear_last) w_state_next = ST_ARB;
      default:  w_state_next = ST_ARB;
    endcase
  end

  // During CLEAR the output address register doubles as the clear address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr         <= '0;
      r_wren        <= 1'b0;
      r_wraddress   <= '0;
      r_data        <= '0;
      r_clear_done  <= 1'b0;
      r_pixel_count <= '0;
    end else begin
      r_wren       <= 1'b0;
      r_clear_done <= 1'b0;
      if ((r_state == ST_ARB) && clear_start) begin
        r_wren      <= 1'b1;
        r_wraddress <= '0;
        r_data      <= clear_color;
      end else if (r_state == ST_CLEAR) begin
        if (w_clear_last) begin
          r_clear_done  <= 1'b1;
          r_pixel_count <= '0;
        end else begin
          r_wren      <= 1'b1;
          r_wraddress <= r_wraddress + 1'b1;
        end
      end else begin
        if (w_xfer) begin
          r_ptr <= (w_gnt_idx == c_LAST_REQ) ? '0 : w_gnt_idx + 1'b1;
        end
        if (w_write) begin
          r_wren      <= 1'b1;
          r_wraddress <= w_gnt_addr;
          r_data      <= w_gnt_data;
          if (r_pixel_count != c_FRAME_PIXELS) begin
            r_pixel_count <= r_pixel_count + 1'b1;
          end
        end
      end
    end
  end

  assign clear_busy  = (r_state == ST_CLEAR);
  assign clear_done  = r_clear_done;
  assign wren        = r_wren;
  assign wraddress   = r_wraddress;
  assign data        = r_data;
  assign pixel_count = r_pixel_count;
  assign frame_done  = (r_pixel_count == c_FRAME_PIXELS);

endmodule
`default_nettype wire

// File: tb/tb_fract_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fract_write_arbiter
// Function : Randomised bench for fract_write_arbiter against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fract_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 19;
  localparam int DW = 3;
  localparam int FP = 200;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            clear_start = 1'b0;
  logic [DW-1:0]   clear_color = '0;
  logic            clear_busy;
  logic            clear_done;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   wraddress;
  logic [DW-1:0]   data;
  logic            wren;
  logic [AW-1:0]   pixel_count;
  logic            frame_done;

  fract_write_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(FP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .wraddress(wraddress), .data(data), .wren(wren),
    .pixel_count(pixel_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state, in plain integers.
  bit m_clear;
  bit m_wren;
  bit m_done;
  int m_ptr;
  int m_addr;
  int m_data;
  int m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int slot_addr(input int i);
    logic [AW-1:0] a;
    a = req_addr[i*AW +: AW];
    return int'(a);
  endfunction

  function automatic int slot_data(input int i);
    logic [DW-1:0] d;
    d = req_data[i*DW +: DW];
    return int'(d);
  endfunction

  function automatic int exp_grant();
    if (!reset_n || m_clear || clear_start) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_clear = 0; m_wren = 0; m_done = 0;
    m_ptr = 0; m_addr = 0; m_data = 0; m_cnt = 0;
  endtask

  task automatic model_update();
    int  g;
    bit  ok;
    g = exp_grant();
    m_done = 0;
    if (m_clear) begin
      if (m_addr == FP - 1) begin
        m_clear = 0; m_wren = 0; m_done = 1; m_cnt = 0;
      end else begin
        m_addr++;
      end
    end else if (clear_start) begin
      m_clear = 1; m_wren = 1; m_addr = 0; m_data = int'(clear_color);
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
`ifdef FRACT_ARB_BOUNDS_CHECK_EN
      ok = (slot_addr(g) < FP);
`else
      ok = 1;
`endif
      m_wren = ok;
      if (ok) begin
        m_addr = slot_addr(g);
        m_data = slot_data(g);
        if (m_cnt < FP) m_cnt++;
      end
    end else begin
      m_wren = 0;
    end
  endtask

  task automatic check_all();
    int g;
    logic [N-1:0] er;
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("wren", wren, m_wren);
    chk("wraddress", wraddress, m_addr);
    chk("data", data, m_data);
    chk("clear_busy", clear_busy, m_clear);
    chk("clear_done", clear_done, m_done);
    chk("pixel_count", pixel_count, m_cnt);
    chk("frame_done", frame_done, m_cnt == FP);
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic hard_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_wren", wren, 0);
    chk("rst_wraddress", wraddress, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_count", pixel_count, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_ready", req_ready, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic rand_inputs(input int clr_per_mille);
    req_valid = N'($urandom);
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'($urandom_range(0, FP + 30));
      req_data[i*DW +: DW] = DW'($urandom);
    end
    clear_start = ($urandom_range(0, 999) < clr_per_mille);
    clear_color = DW'($urandom);
  endtask

  initial begin
    int  nwr;
    bit  got_done;
    bit  busy_at_done;
    bit  saw_frame_done;

    req_valid = '1;
    hard_reset();
    req_valid = '0;
    step();

    // Single requester on slot 2.
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = AW'(100);
    req_data[2*DW +: DW] = DW'(6);
    #1 chk("solo_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    #1;
    chk("solo_wren", wren, 1);
    chk("solo_addr", wraddress, 100);
    chk("solo_data", data, 6);
    chk("solo_count", pixel_count, 1);
    step();

    // Continuous round robin from pointer 0.
    hard_reset();
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(10 + i);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_grant", req_ready, 4'b0001 << (k % 4));
      if (k > 0) chk("rr_wren", wren, 1);
      step();
    end
    req_valid = '0;

    // Clear has priority over simultaneous requests.
    clear_start = 1'b1;
    clear_color = 3'b101;
    req_valid   = '1;
    #1 chk("clr_prio_ready", req_ready, 0);
    step();
    clear_start = 1'b0;
    nwr = 0; got_done = 0; busy_at_done = 1;
    for (int c = 0; c < FP + 10 && !got_done; c++) begin
      clear_start = (c < FP - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_valid   = N'($urandom);
      #1;
      if (clear_done) begin
        got_done = 1;
        busy_at_done = clear_busy;
      end else if (wren && clear_busy && wraddress == AW'(nwr) && data == 3'b101) begin
        nwr++;
      end
      step();
    end
    clear_start = 1'b0;
    chk("clr_writes", nwr, FP);
    chk("clr_done_seen", got_done, 1);
    chk("clr_busy_at_done", busy_at_done, 0);

    // Reset pulse in the middle of a clear.
    req_valid   = '0;
    clear_start = 1'b1;
    clear_color = 3'b011;
    step();
    clear_start = 1'b0;
    repeat (50) step();
    #1 chk("mid_clr_addr", wraddress, 50);
    hard_reset();
    step();
    #1 chk("post_rst_busy", clear_busy, 0);
    step();

`ifdef FRACT_ARB_BOUNDS_CHECK_EN
    hard_reset();
    req_valid = 4'b0001;
    req_addr[0 +: AW] = AW'(FP);
    #1 chk("oob_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    #1;
    chk("oob_wren", wren, 0);
    chk("oob_count", pixel_count, 0);
    step();
`endif

    // Random traffic without clears, long enough to saturate the counter.
    hard_reset();
    saw_frame_done = 0;
    for (int c = 0; c < 400; c++) begin
      rand_inputs(0);
      step();
    end
    #1 chk("saturated", frame_done, 1);

    // Random traffic with occasional clears.
    for (int c = 0; c < 3000; c++) begin
      rand_inputs(5);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
